// File: rtl/aes_sched_pkg.sv
// Shared widths and the issue-FSM state type for the AES request scheduler.
package aes_sched_pkg;
  localparam int KEY_W = 256;
  localparam int PT_W  = 128;
  localparam int REQ_W = 384;
  localparam int BUS_W = 512;
  localparam int CT_W  = 128;

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_HOLD = 1'b1
  } issue_state_t;
endpackage

// File: rtl/aes_sched_id_fifo.sv
// In-order FIFO of requester IDs for blocks in flight inside the AES core.
module aes_sched_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler sharing one AES core among N_REQ requesters; responses
// come back in issue order tagged with the requester ID.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 4,
  localparam int ID_W  = $clog2(N_REQ),
  localparam int CNT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*REQ_W-1:0] req_data,
  output logic                   core_tvalid,
  input  logic                   core_tready,
  output logic [BUS_W-1:0]       core_tdata,
  input  logic                   cres_tvalid,
  output logic                   cres_tready,
  input  logic [BUS_W-1:0]       cres_tdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   err_orphan
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // source holds valid and data stable until that edge, ready may toggle freely.
  issue_state_t    state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            can_grant;
  logic            req_hs;
  logic            core_hs;
  logic            cres_hs;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            unused_cres;

  assign unused_cres = ^cres_tdata[BUS_W-1:CT_W];

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign core_tvalid = (state == ISSUE_HOLD);
  assign can_grant   = !rst && (state == ISSUE_IDLE) && !fifo_full;
  assign req_ready   = (can_grant && grant_found) ? (N_REQ'(1) << grant_idx) : '0;
  assign req_hs      = |(req_valid & req_ready);
  assign core_hs     = core_tvalid && core_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE_IDLE: if (req_hs)  state_nxt = ISSUE_HOLD;
      ISSUE_HOLD: if (core_hs) state_nxt = ISSUE_IDLE;
      default:                 state_nxt = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE_IDLE;
      core_tdata <= '0;
      rr_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        core_tdata <= {{(BUS_W-REQ_W){1'b0}}, req_data[grant_idx*REQ_W +: REQ_W]};
        rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  assign cres_tready = !rst && (!rsp_valid || rsp_ready);
  assign cres_hs     = cres_tvalid && cres_tready;
  assign fifo_pop    = cres_hs && !fifo_empty;

  // Results arriving with no ID to pair with are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (fifo_pop) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cres_tdata[CT_W-1:0];
        rsp_id    <= fifo_head;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (cres_hs && fifo_empty) err_orphan <= 1'b1;
    end
  end

  aes_sched_id_fifo #(
    .DEPTH(MAX_OUTST),
    .WIDTH(ID_W)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_hs),
    .push_data(grant_idx),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );
endmodule
